// File: rtl/nabp_pkg.sv
// rtl/nabp_pkg.sv - shared lengths and FSM state encoding for the NABP image collector
package nabp_pkg;

  localparam int DATA_LEN = 32;
  localparam int ADDR_LEN = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/nabp_image_fifo.sv
// rtl/nabp_image_fifo.sv - capture buffer with first-word-fall-through head
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module nabp_image_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/nabp_image_collector.sv
// rtl/nabp_image_collector.sv - drains NABP image readout into image memory
// Optional hs_checksum output enabled by NABP_IMAGE_CHECKSUM_EN.
module nabp_image_collector import nabp_pkg::*; #(
  parameter int DATA_W     = DATA_LEN,
  parameter int ADDR_W     = ADDR_LEN,
  parameter int FIFO_DEPTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hs_start,
  output logic              hs_busy,
  output logic              hs_done,
  output logic [ADDR_W:0]   hs_pixel_count,
`ifdef NABP_IMAGE_CHECKSUM_EN
  output logic [DATA_W-1:0] hs_checksum,
`endif
  output logic              ir_kick,
  input  logic              ir_kick_ack,
  output logic              ir_enable,
  input  logic              ir_done,
  input  logic [ADDR_W-1:0] ir_addr,
  input  logic [DATA_W-1:0] ir_val,
  output logic              im_wr_en,
  output logic [ADDR_W-1:0] im_wr_addr,
  output logic [DATA_W-1:0] im_wr_data,
  input  logic              im_wr_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] PIX_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PIX_ONE = 1;

  state_t                  state;
  logic [RD_LATENCY-1:0]   en_hist;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           free;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    capture;
  logic                    wr_fire;
  logic                    room;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      inflight = inflight + CW'(en_hist[i]);
  end

  // The enable being driven now is also committed, so count it alongside the history.
  assign free    = CW'(FIFO_DEPTH) - fifo_count;
  assign room    = free > (inflight + CW'(ir_enable));
  assign capture = en_hist[RD_LATENCY-1];
  assign wr_fire = im_wr_en && im_wr_ready;
  assign im_wr_en = !fifo_empty;
  assign hs_busy  = (state != S_IDLE);

  nabp_image_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture && !fifo_full),
    .push_data ({ir_addr, ir_val}),
    .pop       (wr_fire),
    .head      ({im_wr_addr, im_wr_data}),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      ir_kick        <= 1'b0;
      ir_enable      <= 1'b0;
      hs_done        <= 1'b0;
      hs_pixel_count <= '0;
      en_hist        <= '0;
`ifdef NABP_IMAGE_CHECKSUM_EN
      hs_checksum    <= '0;
`endif
    end else begin
      en_hist[0] <= ir_enable;
      for (int i = 1; i < RD_LATENCY; i++)
        en_hist[i] <= en_hist[i-1];
      hs_done <= 1'b0;
      if (wr_fire && hs_pixel_count != PIX_MAX)
        hs_pixel_count <= hs_pixel_count + PIX_ONE;
`ifdef NABP_IMAGE_CHECKSUM_EN
      if (wr_fire)
        hs_checksum <= hs_checksum ^ im_wr_data;
`endif
      case (state)
        S_IDLE: begin
          if (hs_start) begin
            state          <= S_KICK;
            ir_kick        <= 1'b1;
            hs_pixel_count <= '0;
`ifdef NABP_IMAGE_CHECKSUM_EN
            hs_checksum    <= '0;
`endif
          end
        end
        S_KICK: begin
          if (ir_kick_ack) begin
            state   <= S_STREAM;
            ir_kick <= 1'b0;
          end
        end
        S_STREAM: begin
          if (ir_done) begin
            state     <= S_DRAIN;
            ir_enable <= 1'b0;
          end else begin
            ir_enable <= room;
          end
        end
        S_DRAIN: begin
          if (inflight == '0 && fifo_empty) begin
            state   <= S_DONE;
            hs_done <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
